// File: rtl/axis_fifo_upsizer.sv
// AXI-Stream width up-converter: packs RATIO narrow beats (first beat in the LSBs) into one registered wide beat.
// Optional partial-group flush with beat count is enabled by defining AXIS_UPSIZE_FLUSH_EN.

package axis_fifo_pkg_prm;
  localparam int AXI_DATA_WIDTH = 8;
endpackage

module axis_fifo_upsizer
  import axis_fifo_pkg_prm::*;
#(
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
`ifdef AXIS_UPSIZE_FLUSH_EN
  input  logic                       s_flush,
  output logic [$clog2(RATIO+1)-1:0] m_axis_tbeats,
`endif
  output logic [OUT_WIDTH-1:0]       m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ACC_W = (RATIO - 1) * DATA_WIDTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;

  logic out_free_s;
  logic last_slot_s;
  logic ready_base_s;
  logic flush_s;
  logic in_xfer_s;

`ifdef AXIS_UPSIZE_FLUSH_EN
  localparam int BEATS_W = $clog2(RATIO + 1);
  logic [BEATS_W-1:0]   beats_q, beats_d;
  logic [OUT_WIDTH-1:0] partial_s;
`endif

  // Handshake qualification: only the final slot waits for the output register to free up.
  always_comb begin
    out_free_s   = !m_valid_q || m_axis_tready;
    last_slot_s  = (idx_q == IDX_LAST);
    if (last_slot_s) begin
      ready_base_s = out_free_s;
    end else begin
      ready_base_s = 1'b1;
    end
`ifdef AXIS_UPSIZE_FLUSH_EN
    // A flush yields to a real input transfer and stays pending while s_flush is held.
    flush_s = s_flush && (idx_q != {IDX_W{1'b0}}) && out_free_s && !(s_axis_tvalid && ready_base_s);
`else
    flush_s = 1'b0;
`endif
    s_axis_tready = ready_base_s && !flush_s;
    in_xfer_s     = s_axis_tvalid && s_axis_tready;
  end

`ifdef AXIS_UPSIZE_FLUSH_EN
  // Partial word for a flush: filled slots from the accumulator, unfilled slots zero.
  always_comb begin
    partial_s = {OUT_WIDTH{1'b0}};
    for (int k = 0; k < RATIO - 1; k++) begin
      if (IDX_W'(k) < idx_q) begin
        partial_s[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        partial_s[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end
`endif

  // Next-state: accumulate, load the output word on completion, drop valid on an unreplaced drain.
  always_comb begin
    idx_d     = idx_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
`ifdef AXIS_UPSIZE_FLUSH_EN
    beats_d   = beats_q;
`endif
    if (in_xfer_s && last_slot_s) begin
      m_data_d  = {s_axis_tdata, acc_q};
      m_valid_d = 1'b1;
      idx_d     = {IDX_W{1'b0}};
`ifdef AXIS_UPSIZE_FLUSH_EN
      beats_d   = BEATS_W'(RATIO);
`endif
    end else if (in_xfer_s) begin
      acc_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
      idx_d = idx_q + IDX_W'(1);
      if (m_axis_tready) begin
        m_valid_d = 1'b0;
      end else begin
        m_valid_d = m_valid_q;
      end
    end else if (flush_s) begin
`ifdef AXIS_UPSIZE_FLUSH_EN
      m_data_d  = partial_s;
      beats_d   = BEATS_W'(idx_q);
`endif
      m_valid_d = 1'b1;
      idx_d     = {IDX_W{1'b0}};
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State registers; reset discards any partial group and any pending output word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q     <= {IDX_W{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      m_data_q  <= {OUT_WIDTH{1'b0}};
      m_valid_q <= 1'b0;
`ifdef AXIS_UPSIZE_FLUSH_EN
      beats_q   <= {BEATS_W{1'b0}};
`endif
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
`ifdef AXIS_UPSIZE_FLUSH_EN
      beats_q   <= beats_d;
`endif
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
`ifdef AXIS_UPSIZE_FLUSH_EN
  assign m_axis_tbeats = beats_q;
`endif

endmodule

// File: tb/tb_axis_fifo_upsizer.sv
// Scoreboard bench for axis_fifo_upsizer (DATA_WIDTH=8, RATIO=4); flush checks run when AXIS_UPSIZE_FLUSH_EN is defined.
module tb_axis_fifo_upsizer;
  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          s_flush;
  logic [2:0]    m_tbeats;

  typedef struct {
    logic [OW-1:0] data;
    int            beats;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] beats_q[$];
  int            checks = 0;
  int            errors = 0;
  int            out_count = 0;
  int            cyc = 0;
  bit            expect_valid = 1'b0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  bit            strict_ready = 1'b0;

  axis_fifo_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
`ifdef AXIS_UPSIZE_FLUSH_EN
    .s_flush       (s_flush),
    .m_axis_tbeats (m_tbeats),
`endif
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference packing: beat k is worth data << (DW*k); unfilled slots contribute nothing.
  function automatic logic [OW-1:0] pack_beats();
    logic [OW-1:0] w = '0;
    foreach (beats_q[k]) w = w | (OW'(beats_q[k]) << (DW * k));
    return w;
  endfunction

  // Monitor / scoreboard: everything sampled on the falling edge, between active edges.
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      beats_q.delete();
      exp_q.delete();
      expect_valid = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (expect_valid) chk(m_tvalid == 1'b1, "latency_valid", 64'(m_tvalid), 64'd1);
      expect_valid = 1'b0;
      if (prev_stall) chk(m_tvalid && (m_tdata == prev_data), "hold_stable", 64'(m_tdata), 64'(prev_data));
      if (m_tvalid && m_tready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", 64'(m_tdata), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk(m_tdata == e.data, "out_data", 64'(m_tdata), 64'(e.data));
`ifdef AXIS_UPSIZE_FLUSH_EN
          chk(int'(m_tbeats) == e.beats, "out_beats", 64'(m_tbeats), 64'(e.beats));
`endif
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      if (s_tvalid && s_tready) begin
        beats_q.push_back(s_tdata);
        if (beats_q.size() == R) begin
          e.data  = pack_beats();
          e.beats = R;
          exp_q.push_back(e);
          beats_q.delete();
          expect_valid = 1'b1;
        end
      end
`ifdef AXIS_UPSIZE_FLUSH_EN
      else if (s_flush && beats_q.size() > 0 && (!m_tvalid || m_tready)) begin
        e.data  = pack_beats();
        e.beats = beats_q.size();
        exp_q.push_back(e);
        beats_q.delete();
        expect_valid = 1'b1;
      end
`endif
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input int vprob, input bit rand_rdy);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 200) begin
      s_tdata  = d;
      s_tvalid = ($urandom_range(99) < vprob);
      if (rand_rdy) m_tready = 1'($urandom_range(1));
      @(negedge aclk);
      acc = s_tvalid && s_tready;
      if (strict_ready) chk(s_tready == 1'b1, "stream_ready", 64'(s_tready), 64'd1);
      @(posedge aclk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    if (!acc) chk(1'b0, "accept_timeout", 64'(n), 64'd200);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge aclk);
    chk(m_tvalid == 1'b0, {tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk(m_tdata == '0, {tag, "_tdata"}, 64'(m_tdata), 64'd0);
    chk(s_tready == 1'b1, {tag, "_tready"}, 64'(s_tready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, n0, acc_cnt;
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    s_flush  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_state("reset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Reset in the middle of a group
    drive_beat(8'h11, 100, 1'b0);
    drive_beat(8'h22, 100, 1'b0);
    aresetn = 1'b0;
    check_reset_state("midreset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    n0 = out_count;
    for (int i = 1; i <= 4; i++) drive_beat(DW'(i), 100, 1'b0);
    idle(4);
    chk(out_count - n0 == 1, "reset_one_word", 64'(out_count - n0), 64'd1);

    // Back-to-back streaming
    n0 = out_count;
    strict_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) drive_beat(DW'(i), 100, 1'b0);
    strict_ready = 1'b0;
    chk(cyc - t0 == 16, "stream_cycles", 64'(cyc - t0), 64'd16);
    idle(3);
    chk(out_count - n0 == 4, "stream_words", 64'(out_count - n0), 64'd4);

    // Back-pressure: 8 beats offered, 7 accepted
    m_tready = 1'b0;
    acc_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DW'(8'h20 + acc_cnt);
      @(negedge aclk);
      if (i == 9) chk(s_tready == 1'b0, "bp_last_blocked", 64'(s_tready), 64'd0);
      if (s_tready) acc_cnt++;
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    chk(acc_cnt == 7, "bp_accepted", 64'(acc_cnt), 64'd7);
    m_tready = 1'b1;
    drive_beat(8'h27, 100, 1'b0);
    idle(3);

    // Drain and reload in the same cycle
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) drive_beat(DW'(8'h40 + i), 100, 1'b0);
    m_tready = 1'b1;
    drive_beat(8'h47, 100, 1'b0);
    m_tready = 1'b0;
    @(negedge aclk);
    chk(m_tvalid == 1'b1, "no_bubble", 64'(m_tvalid), 64'd1);
    chk(m_tdata == 32'h47464544, "reload_word", 64'(m_tdata), 64'h47464544);
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    idle(3);

`ifdef AXIS_UPSIZE_FLUSH_EN
    // Flush of a partial group
    drive_beat(8'hAA, 100, 1'b0);
    drive_beat(8'hBB, 100, 1'b0);
    s_flush = 1'b1;
    @(negedge aclk);
    chk(s_tready == 1'b0, "flush_tready", 64'(s_tready), 64'd0);
    @(posedge aclk);
    #1;
    s_flush = 1'b0;
    @(negedge aclk);
    chk(m_tvalid == 1'b1, "flush_valid", 64'(m_tvalid), 64'd1);
    chk(m_tdata == 32'h0000BBAA, "flush_data", 64'(m_tdata), 64'h0000BBAA);
    chk(m_tbeats == 3'd2, "flush_beats", 64'(m_tbeats), 64'd2);
    @(posedge aclk);
    #1;
    for (int i = 1; i <= 4; i++) drive_beat(DW'(i), 100, 1'b0);
    idle(3);
`endif

    // Random stress
    for (int i = 0; i < 1000; i++) drive_beat(DW'($urandom), 50, 1'b1);
    m_tready = 1'b1;
    idle(10);
    chk(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'd0);
    chk(beats_q.size() == 0, "no_residue", 64'(beats_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
